// File: rtl/aqua_pkg.sv
// Shared pipeline types: execution-lane result packet and write-back buffer entries.
package aqua_pkg;

    localparam int XLEN          = 32;
    localparam int WB_BUFF_DEPTH = 4;

    typedef logic [4:0] register_idx;

    typedef struct packed {
        logic [XLEN-1:0] data_buff;
        register_idx     rd_buff;
        logic            wr_en;
        logic            valid;
        logic            is_instr2;
    } uv_buff_t;

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        register_idx     rd;
        logic [XLEN-1:0] data;
    } wb_slot_t;

    typedef struct packed {
        wb_slot_t slot0;
        wb_slot_t slot1;
    } wb_bundle_t;

    function automatic wb_slot_t to_slot(input uv_buff_t p);
        wb_slot_t s;
        s.valid = p.valid;
        s.wr_en = p.wr_en;
        s.rd    = p.rd_buff;
        s.data  = p.data_buff;
        return s;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic registered FIFO: push/pop with simultaneous push+pop allowed when full.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop frees the head slot at the same edge, so a full FIFO can still take a push.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // NOTE: the storage is a handful of flops and its valid bits must read as cleared
    // after reset, so it is reset with the pointers; a RAM-backed FIFO would not do this.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/exe_wb_buffer.sv
// Orders two lane results into instr1/instr2 bundles, queues them, and drains one
// bundle per cycle to the register-file write ports with x0 and WAW masking.
module exe_wb_buffer
    import aqua_pkg::*;
#(
    parameter int DEPTH = WB_BUFF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  uv_buff_t        i_lane0_buff_pkg,
    input  uv_buff_t        i_lane1_buff_pkg,
    input  logic            i_wb_ready,
    output logic            o_wb0_valid,
    output logic            o_wb1_valid,
    output register_idx     o_wb0_rd,
    output register_idx     o_wb1_rd,
    output logic [XLEN-1:0] o_wb0_data,
    output logic [XLEN-1:0] o_wb1_data,
    output logic            o_buff_full,
    output logic            o_buff_empty,
    output logic [CNT_W-1:0] o_count,
    output logic            o_err_overflow,
    output logic            o_err_order
);

    wb_bundle_t w_bundle_in;
    wb_bundle_t w_head;
    logic       w_order_err;
    logic       w_push;
    logic       w_pop;
    logic       w_overflow;
    logic       w_full;
    logic       w_empty;
    logic       w_wr0;
    logic       w_wr1;
    logic       r_err_overflow;
    logic       r_err_order;

    assign w_order_err = i_lane0_buff_pkg.valid & i_lane1_buff_pkg.valid &
                         (i_lane0_buff_pkg.is_instr2 == i_lane1_buff_pkg.is_instr2);
    assign w_push      = i_lane0_buff_pkg.valid | i_lane1_buff_pkg.valid;
    assign w_pop       = i_wb_ready & ~w_empty;
    assign w_overflow  = w_push & w_full & ~w_pop;

    // Slot sorting by is_instr2; on an ordering conflict lane 0 keeps its slot and lane 1 is lost.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_bundle_in = '0;
        if (i_lane0_buff_pkg.valid) begin
            if (i_lane0_buff_pkg.is_instr2) w_bundle_in.slot1 = to_slot(i_lane0_buff_pkg);
            else                            w_bundle_in.slot0 = to_slot(i_lane0_buff_pkg);
        end
        if (i_lane1_buff_pkg.valid & ~w_order_err) begin
            if (i_lane1_buff_pkg.is_instr2) w_bundle_in.slot1 = to_slot(i_lane1_buff_pkg);
            else                            w_bundle_in.slot0 = to_slot(i_lane1_buff_pkg);
        end
    end

    wb_fifo #(
        .WIDTH ($bits(wb_bundle_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_bundle_in),
        .o_dout  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_overflow <= 1'b0;
            r_err_order    <= 1'b0;
        end else begin
            if (w_overflow)  r_err_overflow <= 1'b1;
            if (w_order_err) r_err_order    <= 1'b1;
        end
    end

    assign w_wr0 = w_head.slot0.valid & w_head.slot0.wr_en & (w_head.slot0.rd != '0);
    assign w_wr1 = w_head.slot1.valid & w_head.slot1.wr_en & (w_head.slot1.rd != '0);

    // Same-destination writes inside a bundle: instr2 is younger, so port 0 is suppressed.
    always_comb begin
        o_wb0_valid = 1'b0;
        o_wb1_valid = 1'b0;
        o_wb0_rd    = '0;
        o_wb1_rd    = '0;
        o_wb0_data  = '0;
        o_wb1_data  = '0;
        if (~w_empty) begin
            o_wb1_valid = w_wr1;
            o_wb0_valid = w_wr0 & ~(w_wr1 & (w_head.slot0.rd == w_head.slot1.rd));
            o_wb0_rd    = w_head.slot0.rd;
            o_wb1_rd    = w_head.slot1.rd;
            o_wb0_data  = w_head.slot0.data;
            o_wb1_data  = w_head.slot1.data;
        end
    end

    assign o_buff_full    = w_full;
    assign o_buff_empty   = w_empty;
    assign o_err_overflow = r_err_overflow;
    assign o_err_order    = r_err_order;

endmodule

// File: tb/tb_exe_wb_buffer.sv
// Self-checking bench for exe_wb_buffer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_exe_wb_buffer;
    import aqua_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic            i_clk = 1'b0;
    logic            i_rst;
    uv_buff_t        l0, l1;
    logic            rdy;
    logic            wb0_v, wb1_v;
    register_idx     wb0_rd, wb1_rd;
    logic [31:0]     wb0_d, wb1_d;
    logic            full, empty, err_ov, err_ord;
    logic [CNT_W-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    exe_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_lane0_buff_pkg (l0),
        .i_lane1_buff_pkg (l1),
        .i_wb_ready       (rdy),
        .o_wb0_valid      (wb0_v),
        .o_wb1_valid      (wb1_v),
        .o_wb0_rd         (wb0_rd),
        .o_wb1_rd         (wb1_rd),
        .o_wb0_data       (wb0_d),
        .o_wb1_data       (wb1_d),
        .o_buff_full      (full),
        .o_buff_empty     (empty),
        .o_count          (cnt),
        .o_err_overflow   (err_ov),
        .o_err_order      (err_ord)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a queue of bundles plus sticky flags.
    wb_bundle_t mq[$];
    logic       m_eo, m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic uv_buff_t mk(input logic v, input logic i2, input logic we,
                                    input logic [4:0] rd, input logic [31:0] d);
        uv_buff_t p;
        p.valid = v; p.is_instr2 = i2; p.wr_en = we; p.rd_buff = rd; p.data_buff = d;
        return p;
    endfunction

    function automatic wb_bundle_t model_sort(input uv_buff_t a, input uv_buff_t b);
        wb_slot_t s [2];
        logic     taken [2];
        uv_buff_t p;
        wb_bundle_t bun;
        for (int k = 0; k < 2; k++) begin
            s[k] = '0;
            taken[k] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? a : b;
            if (p.valid) begin
                int idx;
                idx = p.is_instr2 ? 1 : 0;
                if (!taken[idx]) begin
                    s[idx].valid = 1'b1;
                    s[idx].wr_en = p.wr_en;
                    s[idx].rd    = p.rd_buff;
                    s[idx].data  = p.data_buff;
                    taken[idx]   = 1'b1;
                end
            end
        end
        bun.slot0 = s[0];
        bun.slot1 = s[1];
        return bun;
    endfunction

    task automatic model_update(input uv_buff_t a, input uv_buff_t b, input logic r);
        logic do_pop;
        do_pop = r && (mq.size() > 0);
        if (a.valid && b.valid && (a.is_instr2 == b.is_instr2)) m_eo = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (a.valid || b.valid) begin
            if (mq.size() < DEPTH) mq.push_back(model_sort(a, b));
            else                   m_ov = 1'b1;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_eo = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic compare_model();
        logic        e_v0, e_v1;
        logic [4:0]  e_rd0, e_rd1;
        logic [31:0] e_d0, e_d1;
        wb_bundle_t  h;
        e_v0 = 0; e_v1 = 0; e_rd0 = 0; e_rd1 = 0; e_d0 = 0; e_d1 = 0;
        if (mq.size() > 0) begin
            h = mq[0];
            e_rd0 = h.slot0.rd; e_rd1 = h.slot1.rd;
            e_d0  = h.slot0.data; e_d1 = h.slot1.data;
            e_v1  = h.slot1.valid && h.slot1.wr_en && (h.slot1.rd != 0);
            e_v0  = h.slot0.valid && h.slot0.wr_en && (h.slot0.rd != 0) &&
                    !(e_v1 && (h.slot0.rd == h.slot1.rd));
        end
        check("m_count", 32'(cnt), 32'(mq.size()));
        check("m_full", 32'(full), 32'(mq.size() == DEPTH));
        check("m_empty", 32'(empty), 32'(mq.size() == 0));
        check("m_wb0_valid", 32'(wb0_v), 32'(e_v0));
        check("m_wb1_valid", 32'(wb1_v), 32'(e_v1));
        check("m_wb0_rd", 32'(wb0_rd), 32'(e_rd0));
        check("m_wb1_rd", 32'(wb1_rd), 32'(e_rd1));
        check("m_wb0_data", wb0_d, e_d0);
        check("m_wb1_data", wb1_d, e_d1);
        check("m_err_order", 32'(err_ord), 32'(m_eo));
        check("m_err_overflow", 32'(err_ov), 32'(m_ov));
    endtask

    task automatic step(input uv_buff_t a, input uv_buff_t b, input logic r);
        @(negedge i_clk);
        l0 = a; l1 = b; rdy = r;
        @(posedge i_clk);
        model_update(a, b, r);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        l0 = '0; l1 = '0; rdy = 1'b0;
        i_rst = 1'b1;
        model_reset();
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(cnt), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        compare_model();
    endtask

    typedef struct {
        uv_buff_t    a, b;
        logic        r;
        logic        v0, v1;
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        int          c;
        logic        eo;
    } vec_t;

    vec_t vecs [9];
    uv_buff_t idle;

    initial begin
        idle  = '0;
        l0 = '0; l1 = '0; rdy = 1'b0;
        i_rst = 1'b1;
        model_reset();
        #1;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_wb0_valid", 32'(wb0_v), 32'd0);
        check("reset_wb1_valid", 32'(wb1_v), 32'd0);
        check("reset_err", {30'd0, err_ov, err_ord}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        vecs[0] = '{mk(1,0,1,5,32'h1234), idle, 1'b1, 1,0, 5,0, 32'h1234,0, 1, 0};
        vecs[1] = '{idle, idle, 1'b1, 0,0, 0,0, 0,0, 0, 0};
        vecs[2] = '{mk(1,1,1,3,32'hAA), mk(1,0,1,4,32'hBB), 1'b0, 1,1, 4,3, 32'hBB,32'hAA, 1, 0};
        vecs[3] = '{mk(1,0,1,7,32'h1), mk(1,1,1,7,32'h2), 1'b1, 0,1, 7,7, 32'h1,32'h2, 1, 0};
        vecs[4] = '{mk(1,0,1,0,32'h55), idle, 1'b1, 0,0, 0,0, 32'h55,0, 1, 0};
        vecs[5] = '{mk(1,0,1,9,32'h99), mk(1,0,1,10,32'h100), 1'b1, 1,0, 9,0, 32'h99,0, 1, 1};
        vecs[6] = '{idle, idle, 1'b1, 0,0, 0,0, 0,0, 0, 1};
        vecs[7] = '{mk(1,0,0,6,32'h66), idle, 1'b1, 0,0, 6,0, 32'h66,0, 1, 1};
        vecs[8] = '{idle, idle, 1'b1, 0,0, 0,0, 0,0, 0, 1};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].r);
            check($sformatf("v%0d_wb0_valid", i), 32'(wb0_v), 32'(vecs[i].v0));
            check($sformatf("v%0d_wb1_valid", i), 32'(wb1_v), 32'(vecs[i].v1));
            check($sformatf("v%0d_wb0_rd", i), 32'(wb0_rd), 32'(vecs[i].rd0));
            check($sformatf("v%0d_wb1_rd", i), 32'(wb1_rd), 32'(vecs[i].rd1));
            check($sformatf("v%0d_wb0_data", i), wb0_d, vecs[i].d0);
            check($sformatf("v%0d_wb1_data", i), wb1_d, vecs[i].d1);
            check($sformatf("v%0d_count", i), 32'(cnt), 32'(vecs[i].c));
            check($sformatf("v%0d_err_order", i), 32'(err_ord), 32'(vecs[i].eo));
        end

        // Fill to full across a pointer wrap, overflow, then drain in order.
        do_reset();
        step(mk(1,0,1,1,32'hE0), idle, 1'b0);
        step(mk(1,0,1,2,32'hE1), idle, 1'b0);
        step(idle, idle, 1'b1);
        step(idle, idle, 1'b1);
        for (int k = 0; k < 4; k++) step(mk(1,0,1,5'(k+1),32'hF000+k), idle, 1'b0);
        check("fill_count", 32'(cnt), 32'd4);
        check("fill_full", 32'(full), 32'd1);
        check("fill_no_ovf", 32'(err_ov), 32'd0);
        step(mk(1,0,1,9,32'hDEAD), idle, 1'b0);
        check("ovf_count", 32'(cnt), 32'd4);
        check("ovf_flag", 32'(err_ov), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_data", k), wb0_d, 32'hF000 + k);
            step(idle, idle, 1'b1);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Push and pop together while full.
        do_reset();
        for (int k = 0; k < 4; k++) step(mk(1,0,1,5'(k+1),32'hA000+k), idle, 1'b0);
        step(mk(1,1,1,12,32'hBEEF), idle, 1'b1);
        check("pp_count", 32'(cnt), 32'd4);
        check("pp_no_ovf", 32'(err_ov), 32'd0);
        check("pp_head", wb0_d, 32'hA001);
        for (int k = 0; k < 3; k++) step(idle, idle, 1'b1);
        check("pp_fourth_data", wb1_d, 32'hBEEF);
        check("pp_fourth_valid", 32'(wb1_v), 32'd1);

        // Asynchronous reset mid-drain with three entries queued.
        do_reset();
        for (int k = 0; k < 3; k++) step(mk(1,0,1,5'(k+2),32'hC000+k), mk(1,1,1,5'(k+10),32'hD000+k), 1'b0);
        @(negedge i_clk);
        l0 = '0; l1 = '0; rdy = 1'b1;
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(cnt), 32'd0);
        check("arst_valids", {30'd0, wb0_v, wb1_v}, 32'd0);
        check("arst_data", wb0_d | wb1_d, 32'd0);
        check("arst_rd", 32'(wb0_rd | wb1_rd), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(mk(1,0,1,11,32'h5151), idle, 1'b0);
        check("post_rst_valid", 32'(wb0_v), 32'd1);
        check("post_rst_data", wb0_d, 32'h5151);

        // Randomized traffic; early phase biases toward backpressure to reach full.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            uv_buff_t a, b;
            logic r;
            a = mk($urandom_range(0,9) < 6, 1'($urandom), 1'($urandom_range(0,7) != 0),
                   5'($urandom_range(0,7)), $urandom);
            b = mk($urandom_range(0,1) == 1, 1'($urandom), 1'($urandom_range(0,7) != 0),
                   5'($urandom_range(0,7)), $urandom);
            r = (n < 120) ? ($urandom_range(0,9) < 3) : ($urandom_range(0,9) < 7);
            step(a, b, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
